// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: port-B sequencer sharing soft_ecc_ram_16bit between a user requester and a background scrubber.
// Latency: user ops issue in the usr_ack cycle; usr_rvalid follows RD_LATENCY cycles later; scrub writeback 1 cycle after response.
// Backpressure: usr_ack withheld while a scrub is in flight; ECC_SCRUB_STATS_EN adds error counters and lets user writes through.
module ecc_scrub_ctrl #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_BITS      = 16,
    parameter int RD_LATENCY     = 4,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  usr_req,
    input  logic                  usr_we,
    input  logic [ADDR_WIDTH-1:0] usr_addr,
    input  logic [DATA_BITS-1:0]  usr_wdata,
    output logic                  usr_ack,
    output logic                  usr_rvalid,
    output logic [DATA_BITS-1:0]  usr_rdata,
    output logic [2:0]            usr_rerr,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic [DATA_BITS-1:0]  ram_data_b,
    output logic                  ram_wren_b,
    input  logic [DATA_BITS-1:0]  ram_q_b,
    input  logic [2:0]            ram_err_b,
    output logic [ADDR_WIDTH-1:0] scrub_addr,
    output logic                  uncorr_flag,
    output logic [ADDR_WIDTH-1:0] uncorr_addr,
`ifdef ECC_SCRUB_STATS_EN
    output logic [15:0]           corr_count,
    output logic [15:0]           uncorr_count,
`endif
    input  logic                  clr_flag
);

    localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SCRUB_INTERVAL);

    typedef enum logic [1:0] {IDLE, SCRUB_WAIT, WB} state_t;

    typedef struct packed {
        logic                  vld;
        logic                  scrub;
        logic [ADDR_WIDTH-1:0] addr;
    } tag_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] scrub_addr_q, scrub_addr_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_BITS-1:0]  wb_data_q, wb_data_d;
    logic                  cancel_q, cancel_d;
    logic                  uflag_q, uflag_d;
    logic [ADDR_WIDTH-1:0] uaddr_q, uaddr_d;
    tag_t                  pipe_q [RD_LATENCY];
    tag_t                  issue_tag;
    tag_t                  resp;
    logic                  resp_corr, resp_uncorr;

    // The tag leaving the pipe lines up with ram_q_b/ram_err_b for that read.
    assign resp        = pipe_q[RD_LATENCY-1];
    assign resp_uncorr = resp.vld & ram_err_b[1];
    assign resp_corr   = resp.vld & (ram_err_b[0] | ram_err_b[2]) & ~ram_err_b[1];

    assign usr_rvalid  = resp.vld & ~resp.scrub;
    assign usr_rdata   = usr_rvalid ? ram_q_b : '0;
    assign usr_rerr    = usr_rvalid ? ram_err_b : 3'b000;
    assign scrub_addr  = scrub_addr_q;
    assign uncorr_flag = uflag_q;
    assign uncorr_addr = uaddr_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        scrub_addr_d  = scrub_addr_q;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        cancel_d      = cancel_q;
        issue_tag     = '0;
        usr_ack       = 1'b0;
        ram_address_b = '0;
        ram_data_b    = '0;
        ram_wren_b    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rst_n gating keeps the RAM port quiet while reset is held.
                if (usr_req && rst_n) begin
                    usr_ack         = 1'b1;
                    ram_address_b   = usr_addr;
                    ram_wren_b      = usr_we;
                    ram_data_b      = usr_we ? usr_wdata : '0;
                    issue_tag.vld   = ~usr_we;
                    issue_tag.scrub = 1'b0;
                    issue_tag.addr  = usr_addr;
                end else if (cnt_q == '0 && rst_n) begin
                    ram_address_b   = scrub_addr_q;
                    issue_tag.vld   = 1'b1;
                    issue_tag.scrub = 1'b1;
                    issue_tag.addr  = scrub_addr_q;
                    cnt_d           = CNT_RELOAD;
                    cancel_d        = 1'b0;
                    state_d         = SCRUB_WAIT;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SCRUB_WAIT: begin
`ifdef ECC_SCRUB_STATS_EN
                if (usr_req && usr_we) begin
                    usr_ack       = 1'b1;
                    ram_address_b = usr_addr;
                    ram_wren_b    = 1'b1;
                    ram_data_b    = usr_wdata;
                    if (usr_addr == scrub_addr_q) cancel_d = 1'b1;
                end
`endif
                if (resp.vld && resp.scrub) begin
                    scrub_addr_d = scrub_addr_q + 1'b1;
                    wb_addr_d    = resp.addr;
                    wb_data_d    = ram_q_b;
                    state_d      = resp_corr ? WB : IDLE;
                end
            end
            WB: begin
                // A newer user write to the same word must not be overwritten with stale data.
                if (!cancel_q) begin
                    ram_wren_b    = 1'b1;
                    ram_address_b = wb_addr_q;
                    ram_data_b    = wb_data_q;
                end
                cancel_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uflag_d = uflag_q;
        uaddr_d = uaddr_q;
        if (clr_flag) begin
            uflag_d = 1'b0;
            uaddr_d = '0;
        end
        if (resp_uncorr && (!uflag_q || clr_flag)) begin
            uflag_d = 1'b1;
            uaddr_d = resp.addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_RELOAD;
            scrub_addr_q <= '0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            cancel_q     <= 1'b0;
            uflag_q      <= 1'b0;
            uaddr_q      <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scrub_addr_q <= scrub_addr_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            cancel_q     <= cancel_d;
            uflag_q      <= uflag_d;
            uaddr_q      <= uaddr_d;
            pipe_q[0]    <= issue_tag;
            for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

`ifdef ECC_SCRUB_STATS_EN
    logic [15:0] corr_cnt_q, uncorr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (clr_flag) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (resp_corr && corr_cnt_q != 16'hFFFF) corr_cnt_q <= corr_cnt_q + 1'b1;
            if (resp_uncorr && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
        end
    end

    assign corr_count   = corr_cnt_q;
    assign uncorr_count = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl (SCRUB_INTERVAL=2) driving a behavioural 4-cycle-latency RAM with injectable err_b.
module tb_ecc_scrub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        usr_req = 1'b0, usr_we = 1'b0;
    logic [8:0]  usr_addr = '0;
    logic [15:0] usr_wdata = '0;
    logic        usr_ack, usr_rvalid, ram_wren_b, uncorr_flag;
    logic [15:0] usr_rdata, ram_data_b, ram_q_b;
    logic [2:0]  usr_rerr, ram_err_b;
    logic [8:0]  ram_address_b, scrub_addr, uncorr_addr;
    logic        clr_flag = 1'b0;
`ifdef ECC_SCRUB_STATS_EN
    logic [15:0] corr_count, uncorr_count;
`endif

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(.ADDR_WIDTH(9), .DATA_BITS(16), .RD_LATENCY(4), .SCRUB_INTERVAL(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
        .usr_ack(usr_ack), .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata), .usr_rerr(usr_rerr),
        .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
        .ram_q_b(ram_q_b), .ram_err_b(ram_err_b),
        .scrub_addr(scrub_addr), .uncorr_flag(uncorr_flag), .uncorr_addr(uncorr_addr),
`ifdef ECC_SCRUB_STATS_EN
        .corr_count(corr_count), .uncorr_count(uncorr_count),
`endif
        .clr_flag(clr_flag)
    );

    // ---------------- RAM model and monitors ----------------
    typedef struct { int cyc; logic [15:0] dat; logic [2:0] err; } rv_t;

    logic [15:0] mem  [512];
    logic [2:0]  etbl [512];
    logic [8:0]  rp   [4] = '{default: 9'h000};
    bit          loaded = 1'b0;
    int          cyc = 0;
    int          wr_cnt = 0, wr_cyc_l = 0, corr_cyc_l = 0;
    logic [8:0]  wr_addr_l = '0;
    logic [15:0] wr_dat_l = '0;
    rv_t         rlog [$];
    logic        poke_vld = 1'b0;
    logic [8:0]  poke_addr = '0;
    logic [15:0] poke_dat = '0;
    logic [2:0]  poke_err = '0;

    assign ram_q_b   = mem[rp[3]];
    assign ram_err_b = etbl[rp[3]];

    always @(posedge clk) begin
        rp[0] <= ram_address_b;
        for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 512; i++) begin
                mem[i]  = 16'h5A00 ^ 16'(i);
                etbl[i] = 3'b000;
            end
            loaded = 1'b1;
        end
        if (usr_rvalid) rlog.push_back('{cyc, usr_rdata, usr_rerr});
        if (ram_err_b == 3'b001) corr_cyc_l = cyc;
        if (ram_wren_b) begin
            wr_cnt++;
            wr_addr_l = ram_address_b;
            wr_dat_l  = ram_data_b;
            wr_cyc_l  = cyc;
            mem[ram_address_b]  = ram_data_b;
            etbl[ram_address_b] = 3'b000;
        end
        if (poke_vld) begin
            mem[poke_addr]  = poke_dat;
            etbl[poke_addr] = poke_err;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [8:0] a, input logic [15:0] d, input logic [2:0] e);
        tick();
        poke_addr = a; poke_dat = d; poke_err = e; poke_vld = 1'b1;
        @(negedge clk);
        #1 poke_vld = 1'b0;
    endtask

    task automatic wait_sa(input logic [8:0] target, input int budget, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scrub_addr !== target && n < budget);
        chk(nm, 32'(scrub_addr === target), 32'd1);
    endtask

    task automatic wait_sa_change(input string nm);
        logic [8:0] prev = scrub_addr;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scrub_addr === prev && n < 20);
        chk(nm, 32'(scrub_addr !== prev), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_dat;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vec [18];

    initial begin
        int n, base_wr, base_log, ackc, k;
        int t [3];
        int ack_cyc [18];
        logic [8:0] sa;
        logic got;

        vec[0]  = '{1'b0, 9'h000, 16'h0000, 16'h5A00, 3'b000};
        vec[1]  = '{1'b0, 9'h001, 16'h0000, 16'h5A01, 3'b000};
        vec[2]  = '{1'b0, 9'h002, 16'h0000, 16'h5A02, 3'b000};
        vec[3]  = '{1'b0, 9'h003, 16'h0000, 16'h5A03, 3'b001};
        vec[4]  = '{1'b0, 9'h004, 16'h0000, 16'h5A04, 3'b000};
        vec[5]  = '{1'b0, 9'h005, 16'h0000, 16'h5A05, 3'b000};
        vec[6]  = '{1'b0, 9'h006, 16'h0000, 16'h5A06, 3'b000};
        vec[7]  = '{1'b0, 9'h007, 16'h0000, 16'h5A07, 3'b100};
        vec[8]  = '{1'b0, 9'h008, 16'h0000, 16'h5A08, 3'b000};
        vec[9]  = '{1'b0, 9'h009, 16'h0000, 16'h5A09, 3'b000};
        vec[10] = '{1'b0, 9'h00A, 16'h0000, 16'h5A0A, 3'b000};
        vec[11] = '{1'b0, 9'h00B, 16'h0000, 16'h5A0B, 3'b010};
        vec[12] = '{1'b0, 9'h00C, 16'h0000, 16'h5A0C, 3'b000};
        vec[13] = '{1'b0, 9'h00D, 16'h0000, 16'h5A0D, 3'b000};
        vec[14] = '{1'b0, 9'h00E, 16'h0000, 16'h5A0E, 3'b000};
        vec[15] = '{1'b0, 9'h00F, 16'h0000, 16'h5A0F, 3'b000};
        vec[16] = '{1'b1, 9'h1F0, 16'hBEEF, 16'h0000, 3'b000};
        vec[17] = '{1'b0, 9'h1F0, 16'h0000, 16'hBEEF, 3'b000};

        // Reset, with a user write held high to confirm nothing leaks to the RAM.
        usr_req = 1'b1; usr_we = 1'b1; usr_addr = 9'h1AB; usr_wdata = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_usr_ack", 32'(usr_ack), 32'd0);
        chk("rst_wren", 32'(ram_wren_b), 32'd0);
        chk("rst_address", 32'(ram_address_b), 32'd0);
        chk("rst_scrub_addr", 32'(scrub_addr), 32'd0);
        chk("rst_uncorr_flag", 32'(uncorr_flag), 32'd0);
        chk("rst_rvalid", 32'(usr_rvalid), 32'd0);
        tick();
        usr_req = 1'b0; usr_we = 1'b0; usr_wdata = '0;
        rst_n = 1'b1;

        // Full sweep of a clean RAM: 512 increments ending in a wrap to 0.
        base_wr = wr_cnt;
        n = 0;
        sa = scrub_addr;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (scrub_addr !== sa) begin
                if (n < 3) t[n] = cyc;
                n++;
                sa = scrub_addr;
                if (scrub_addr == 9'h000) break;
            end
        end
        chk("sweep_count", 32'(n), 32'd512);
        chk("sweep_wrap_addr", 32'(scrub_addr), 32'd0);
        chk("sweep_period", 32'(t[2] - t[1]), 32'd7);
        chk("sweep_no_wren", 32'(wr_cnt - base_wr), 32'd0);
        chk("sweep_uncorr_flag", 32'(uncorr_flag), 32'd0);

        // Correctable error at 0x05A is written back one cycle after the response.
        poke(9'h05A, 16'h1234, 3'b001);
        base_wr = wr_cnt;
        wait_sa(9'h060, 1500, "corr_wait");
        chk("corr_wr_count", 32'(wr_cnt - base_wr), 32'd1);
        chk("corr_wr_addr", 32'(wr_addr_l), 32'h05A);
        chk("corr_wr_data", 32'(wr_dat_l), 32'h1234);
        chk("corr_wr_delay", 32'(wr_cyc_l - corr_cyc_l), 32'd1);

        // Two uncorrectable errors: first address latched, no writeback.
        poke(9'h100, 16'h5B00, 3'b010);
        poke(9'h101, 16'h5B01, 3'b010);
        base_wr = wr_cnt;
        wait_sa(9'h102, 2000, "uncorr_wait");
        chk("uncorr_flag_set", 32'(uncorr_flag), 32'd1);
        chk("uncorr_addr_first", 32'(uncorr_addr), 32'h100);
        chk("uncorr_no_wren", 32'(wr_cnt - base_wr), 32'd0);
        poke(9'h100, 16'h5B00, 3'b000);
        poke(9'h101, 16'h5B01, 3'b000);
        tick();
        clr_flag = 1'b1;
        tick();
        clr_flag = 1'b0;
        @(negedge clk);
        chk("clr_flag", 32'(uncorr_flag), 32'd0);
        chk("clr_addr", 32'(uncorr_addr), 32'd0);

        // User read arrives in the cycle the interval counter reaches 0.
        wait_sa_change("prio_align");
        base_log = rlog.size();
        tick();
        tick();
        usr_req = 1'b1; usr_we = 1'b0; usr_addr = 9'h020;
        @(negedge clk);
        chk("prio_ack", 32'(usr_ack), 32'd1);
        chk("prio_address", 32'(ram_address_b), 32'h020);
        ackc = cyc;
        tick();
        usr_req = 1'b0;
        @(negedge clk);
        chk("prio_scrub_deferred", 32'(ram_address_b), 32'(scrub_addr));
        chk("prio_scrub_read", 32'(ram_wren_b), 32'd0);
        repeat (8) @(negedge clk);
        chk("prio_rvalid_count", 32'(rlog.size() - base_log), 32'd1);
        if (rlog.size() > base_log) begin
            chk("prio_rvalid_latency", 32'(rlog[base_log].cyc), 32'(ackc + 4));
            chk("prio_rdata", 32'(rlog[base_log].dat), 32'h5A20);
            chk("prio_rerr", 32'(rlog[base_log].err), 32'd0);
        end

        // Back-to-back user traffic from the table.
        for (int i = 0; i < 18; i++)
            if (!vec[i].we && vec[i].exp_err != 3'b000) poke(vec[i].addr, vec[i].exp_dat, vec[i].exp_err);
        base_wr  = wr_cnt;
        base_log = rlog.size();
        tick();
        usr_req = 1'b1; usr_we = vec[0].we; usr_addr = vec[0].addr; usr_wdata = vec[0].wdata;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (usr_ack) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("b2b_first_ack", 32'(got), 32'd1);
        ack_cyc[0] = cyc;
        for (int i = 1; i < 18; i++) begin
            tick();
            usr_we = vec[i].we; usr_addr = vec[i].addr; usr_wdata = vec[i].wdata;
            @(negedge clk);
            chk($sformatf("b2b_ack_%0d", i), 32'(usr_ack), 32'd1);
            ack_cyc[i] = cyc;
        end
        tick();
        usr_req = 1'b0; usr_we = 1'b0; usr_wdata = '0;
        repeat (8) @(negedge clk);
        chk("b2b_rvalid_count", 32'(rlog.size() - base_log), 32'd17);
        k = base_log;
        for (int i = 0; i < 18; i++) begin
            if (!vec[i].we && k < rlog.size()) begin
                chk($sformatf("b2b_lat_%0d", i), 32'(rlog[k].cyc), 32'(ack_cyc[i] + 4));
                chk($sformatf("b2b_data_%0d", i), 32'(rlog[k].dat), 32'(vec[i].exp_dat));
                chk($sformatf("b2b_rerr_%0d", i), 32'(rlog[k].err), 32'(vec[i].exp_err));
            end
            if (!vec[i].we) k++;
        end
        chk("b2b_only_user_write", 32'(wr_cnt - base_wr), 32'd1);
        chk("b2b_uncorr_flag", 32'(uncorr_flag), 32'd1);
        chk("b2b_uncorr_addr", 32'(uncorr_addr), 32'h00B);
        poke(9'h003, 16'h5A03, 3'b000);
        poke(9'h007, 16'h5A07, 3'b000);
        poke(9'h00B, 16'h5A0B, 3'b000);

        // Reset while a correctable scrub read is in flight.
        wait_sa_change("rst_align");
        sa = scrub_addr;
        poke(sa, 16'h5A00 ^ 16'(sa), 3'b001);
        tick();
        tick();
        rst_n = 1'b0;
        usr_req = 1'b1; usr_we = 1'b1; usr_addr = sa; usr_wdata = 16'hFFFF;
        base_wr  = wr_cnt;
        base_log = rlog.size();
        @(negedge clk);
        chk("midrst_wren", 32'(ram_wren_b), 32'd0);
        chk("midrst_ack", 32'(usr_ack), 32'd0);
        chk("midrst_scrub_addr", 32'(scrub_addr), 32'd0);
        chk("midrst_uncorr_flag", 32'(uncorr_flag), 32'd0);
        chk("midrst_uncorr_addr", 32'(uncorr_addr), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        usr_req = 1'b0; usr_we = 1'b0; usr_wdata = '0;
        repeat (12) @(negedge clk);
        chk("midrst_no_wren_after", 32'(wr_cnt - base_wr), 32'd0);
        chk("midrst_no_rvalid", 32'(rlog.size() - base_log), 32'd0);
        poke(sa, 16'h5A00 ^ 16'(sa), 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
